vt_channel_engine: RTL and testbench

VT_CHANNEL_ENGINE -- requirements
Module: vt_channel_engine

---
 rtl/vt_engine_pkg.sv | 22 ++
 rtl/vt_vec_fifo.sv | 56 +++++
 rtl/vt_channel_engine.sv | 187 ++++++++++++++++++
 tb/tb_vt_channel_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt_engine_pkg.sv
// ============================================================================
// vt_engine_pkg : shared state encoding and parameter defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package vt_engine_pkg;

  localparam int NUM_CH_DEFAULT = 23;
  localparam int DEPTH_DEFAULT  = 4;
  localparam int CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vt_vec_fifo.sv
// ============================================================================
// vt_vec_fifo : power-of-two vector buffer with full/empty flags
// Rev 1.0
// ============================================================================
`default_nettype none

module vt_vec_fifo
  import vt_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/vt_channel_engine.sv
// ============================================================================
// vt_channel_engine : buffered vector drive / delayed compare pin engine
// Rev 1.0
// ============================================================================
`default_nettype none

module vt_channel_engine
  import vt_engine_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic              vec_last,
  input  logic [NUM_CH-1:0] vec_drv_en,
  input  logic [NUM_CH-1:0] vec_drv_data,
  input  logic [NUM_CH-1:0] vec_cmp_en,
  input  logic [NUM_CH-1:0] vec_exp,
  output logic [NUM_CH-1:0] pin_oe,
  output logic [NUM_CH-1:0] pin_out,
  input  logic [NUM_CH-1:0] pin_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [NUM_CH-1:0] fail_ch
);

  localparam int              EW      = 4 * NUM_CH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e state_q, state_d;

  logic [EW-1:0]     fifo_wdata;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clear;

  logic              ent_last;
  logic [NUM_CH-1:0] ent_drv_en;
  logic [NUM_CH-1:0] ent_drv_data;
  logic [NUM_CH-1:0] ent_cmp_en;
  logic [NUM_CH-1:0] ent_exp;

  logic [NUM_CH-1:0] pin_oe_q, pin_out_q;
  logic [NUM_CH-1:0] cmp_en_q, exp_q;
  logic              cmp_vld_q, cmp_last_q;

  logic [NUM_CH-1:0] mis_bits;
  logic              mismatch;

  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic [NUM_CH-1:0] fail_ch_q, fail_ch_d;

  assign fifo_wdata = {vec_last, vec_drv_en, vec_drv_data, vec_cmp_en, vec_exp};
  assign {ent_last, ent_drv_en, ent_drv_data, ent_cmp_en, ent_exp} = fifo_rdata;

  assign vec_ready = !fifo_full && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign push      = vec_valid && vec_ready;
  assign pop       = (state_q == ST_RUN) && !fifo_empty;

  vt_vec_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Apply stage: the popped entry drives the pads now and is compared one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pin_oe_q   <= '0;
      pin_out_q  <= '0;
      cmp_en_q   <= '0;
      exp_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_last_q <= 1'b0;
    end else begin
      cmp_vld_q <= pop;
      if (pop) begin
        pin_oe_q   <= ent_drv_en;
        pin_out_q  <= ent_drv_data;
        cmp_en_q   <= ent_cmp_en;
        exp_q      <= ent_exp;
        cmp_last_q <= ent_last;
      end
    end
  end

  // If/else form sends an unknown pad level down the mismatch branch.
  always_comb begin
    mis_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!cmp_en_q[i])               mis_bits[i] = 1'b0;
      else if (pin_in[i] == exp_q[i]) mis_bits[i] = 1'b0;
      else                            mis_bits[i] = 1'b1;
    end
    mismatch = |mis_bits;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (pop && ent_last) state_d = ST_DRAIN;
      ST_DRAIN: if (cmp_vld_q && cmp_last_q) state_d = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_cnt_d  = vec_cnt_q;
    fail_cnt_d = fail_cnt_q;
    first_d    = first_q;
    fail_ch_d  = fail_ch_q;
    if (clear) begin
      vec_cnt_d  = '0;
      fail_cnt_d = '0;
      first_d    = '1;
      fail_ch_d  = '0;
    end else if (cmp_vld_q) begin
      if (vec_cnt_q != CNT_MAX) vec_cnt_d = vec_cnt_q + CNT_ONE;
      if (mismatch) begin
        // A zero fail count means no mismatch yet since the last clear.
        if (fail_cnt_q == '0) first_d = vec_cnt_q;
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
        fail_ch_d = fail_ch_q | mis_bits;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      first_q    <= '1;
      fail_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      vec_cnt_q  <= vec_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      first_q    <= first_d;
      fail_ch_q  <= fail_ch_d;
    end
  end

  assign pin_oe         = pin_oe_q;
  assign pin_out        = pin_out_q;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (fail_cnt_q == '0);
  assign vec_cnt        = vec_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_q;
  assign fail_ch        = fail_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_vt_channel_engine.sv
// ============================================================================
// tb_vt_channel_engine : directed bench with queue-based reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vt_channel_engine;

  localparam int NUM_CH = 23;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int SW     = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct packed {
    logic              last;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] drv;
    logic [NUM_CH-1:0] cmp;
    logic [NUM_CH-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic start = 1'b0, vec_valid = 1'b0, vec_last = 1'b0;
  logic [NUM_CH-1:0] vec_drv_en = '0, vec_drv_data = '0, vec_cmp_en = '0, vec_exp = '0;

  logic              a_ready, a_busy, a_done, a_pass;
  logic [NUM_CH-1:0] a_oe, a_out, a_fch;
  logic [CNT_W-1:0]  a_vcnt, a_fcnt, a_first;
  logic              b_ready, b_busy, b_done, b_pass;
  logic [NUM_CH-1:0] b_oe, b_out, b_fch;
  logic [SW-1:0]     b_vcnt, b_fcnt, b_first;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vt_channel_engine #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .vec_valid(vec_valid), .vec_ready(a_ready), .vec_last(vec_last),
    .vec_drv_en(vec_drv_en), .vec_drv_data(vec_drv_data),
    .vec_cmp_en(vec_cmp_en), .vec_exp(vec_exp),
    .pin_oe(a_oe), .pin_out(a_out), .pin_in(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .vec_cnt(a_vcnt), .fail_cnt(a_fcnt), .first_fail_idx(a_first), .fail_ch(a_fch)
  );

  // Narrow-counter copy fed the same vectors, for saturation behaviour.
  vt_channel_engine #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(SW)) dut_sat (
    .clock(clock), .reset(reset), .start(start),
    .vec_valid(vec_valid), .vec_ready(b_ready), .vec_last(vec_last),
    .vec_drv_en(vec_drv_en), .vec_drv_data(vec_drv_data),
    .vec_cmp_en(vec_cmp_en), .vec_exp(vec_exp),
    .pin_oe(b_oe), .pin_out(b_out), .pin_in(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .vec_cnt(b_vcnt), .fail_cnt(b_fcnt), .first_fail_idx(b_first), .fail_ch(b_fch)
  );

  // ---------------- reference model ----------------
  vec_t              q[$];
  vec_t              pend;
  bit                pend_v = 0;
  int                m_st = M_IDLE;
  logic [NUM_CH-1:0] m_oe = '0, m_out = '0, m_fch = '0;
  int                m_vcnt = 0, m_fcnt = 0, m_first = -1;
  int                st0;
  bit                pushed;
  vec_t              nv;
  logic [NUM_CH-1:0] mb;

  function automatic bit m_rdy();
    return (q.size() < DEPTH) && (m_st == M_IDLE || m_st == M_RUN);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      q.delete();
      pend_v = 0; m_st = M_IDLE; m_oe = '0; m_out = '0; m_fch = '0;
      m_vcnt = 0; m_fcnt = 0; m_first = -1;
    end else begin
      st0    = m_st;
      pushed = vec_valid && m_rdy();
      nv     = {vec_last, vec_drv_en, vec_drv_data, vec_cmp_en, vec_exp};
      if (pend_v) begin
        mb = (m_out ^ pend.exp) & pend.cmp;
        if (mb != '0) begin
          if (m_fcnt == 0) m_first = m_vcnt;
          m_fcnt++;
          m_fch |= mb;
        end
        m_vcnt++;
        if (pend.last) m_st = M_DONE;
      end
      pend_v = 0;
      if (st0 == M_RUN && q.size() > 0) begin
        pend   = q.pop_front();
        pend_v = 1;
        m_oe   = pend.en;
        m_out  = pend.drv;
        if (pend.last) m_st = M_DRAIN;
      end else if (start && st0 == M_IDLE) begin
        m_st = M_RUN;
      end else if (start && st0 == M_DONE) begin
        m_st = M_RUN; m_vcnt = 0; m_fcnt = 0; m_first = -1; m_fch = '0;
      end
      if (pushed) q.push_back(nv);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clock);
    chk("a_ready", 64'(a_ready), 64'(m_rdy()));
    chk("a_oe",    64'(a_oe),    64'(m_oe));
    chk("a_out",   64'(a_out),   64'(m_out));
    chk("a_busy",  64'(a_busy),  64'(m_st == M_RUN || m_st == M_DRAIN));
    chk("a_done",  64'(a_done),  64'(m_st == M_DONE));
    chk("a_pass",  64'(a_pass),  64'(m_st == M_DONE && m_fcnt == 0));
    chk("a_vcnt",  64'(a_vcnt),  64'(sat(m_vcnt, 65535)));
    chk("a_fcnt",  64'(a_fcnt),  64'(sat(m_fcnt, 65535)));
    chk("a_first", 64'(a_first), (m_first < 0) ? 64'hFFFF : 64'(sat(m_first, 65535)));
    chk("a_fch",   64'(a_fch),   64'(m_fch));
    chk("b_ready", 64'(b_ready), 64'(m_rdy()));
    chk("b_out",   64'(b_out),   64'(m_out));
    chk("b_done",  64'(b_done),  64'(m_st == M_DONE));
    chk("b_vcnt",  64'(b_vcnt),  64'(sat(m_vcnt, 15)));
    chk("b_fcnt",  64'(b_fcnt),  64'(sat(m_fcnt, 15)));
    chk("b_first", 64'(b_first), (m_first < 0) ? 64'hF : 64'(sat(m_first, 15)));
    chk("b_fch",   64'(b_fch),   64'(m_fch));
  end

  // ---------------- stimulus helpers ----------------
  function automatic vec_t mk(input bit last, input logic [NUM_CH-1:0] inv);
    vec_t v;
    v.last = last;
    v.en   = NUM_CH'($urandom());
    v.drv  = NUM_CH'($urandom());
    v.cmp  = '1;
    v.exp  = v.drv ^ inv;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Entered and left just after a falling edge.
  task automatic push(input vec_t v);
    int n;
    n = 0;
    {vec_last, vec_drv_en, vec_drv_data, vec_cmp_en, vec_exp} = v;
    vec_valid = 1'b1;
    while (!a_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!a_ready) begin
      failures++;
      $display("FAIL push_timeout actual=ready_low required=ready_high t=%0t", $time);
    end
    @(negedge clock);
    vec_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (a_done !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout actual=0 required=1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vl;
    reset = 1'b0;
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;

    chk("rst_oe",    64'(a_oe),    64'h0);
    chk("rst_busy",  64'(a_busy),  64'h0);
    chk("rst_first", 64'(a_first), 64'hFFFF);
    chk("rst_ready", 64'(a_ready), 64'h1);

    // Loopback, 8 matching vectors, two preloaded in IDLE.
    push(mk(0, '0));
    push(mk(0, '0));
    pulse_start();
    for (int i = 2; i < 8; i++) push(mk(i == 7, '0));
    wait_done("lb8");
    chk("lb8_pass",  64'(a_pass),  64'h1);
    chk("lb8_vcnt",  64'(a_vcnt),  64'd8);
    chk("lb8_fcnt",  64'(a_fcnt),  64'd0);
    chk("lb8_first", 64'(a_first), 64'hFFFF);

    // Restart from DONE; vector 3 of 6 expects channel 5 inverted.
    pulse_start();
    for (int i = 0; i < 6; i++) push(mk(i == 5, (i == 3) ? NUM_CH'(32'h20) : '0));
    wait_done("ch5");
    chk("ch5_vcnt",  64'(a_vcnt),  64'd6);
    chk("ch5_fcnt",  64'(a_fcnt),  64'd1);
    chk("ch5_first", 64'(a_first), 64'd3);
    chk("ch5_fch",   64'(a_fch),   64'h20);
    chk("ch5_pass",  64'(a_pass),  64'h0);

    // Preload to full in IDLE, then start; fifth vector waits for a pop.
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) push(mk(0, '0));
    chk("full_ready", 64'(a_ready), 64'h0);
    pulse_start();
    push(mk(1, '0));
    wait_done("pre");
    chk("pre_vcnt", 64'(a_vcnt), 64'd5);
    chk("pre_pass", 64'(a_pass), 64'h1);

    // Gapped vectors in RUN; a start pulse mid-run must be ignored.
    pulse_reset();
    pulse_start();
    vl = '0;
    for (int i = 0; i < 4; i++) begin
      vl = mk(i == 3, '0);
      push(vl);
      if (i == 1) pulse_start();
      tick(3);
    end
    wait_done("gap");
    chk("gap_vcnt", 64'(a_vcnt), 64'd4);
    chk("gap_hold", 64'(a_out),  64'(vl.drv));

    // Reset two cycles after start with four vectors queued.
    pulse_reset();
    for (int i = 0; i < 4; i++) push(mk(0, '0));
    pulse_start();
    tick(2);
    chk("pre_rst_busy", 64'(a_busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_oe",    64'(a_oe),    64'h0);
    chk("mid_rst_busy",  64'(a_busy),  64'h0);
    chk("mid_rst_vcnt",  64'(a_vcnt),  64'h0);
    chk("mid_rst_ready", 64'(a_ready), 64'h1);
    tick(1);
    reset = 1'b0;

    // 20 failing vectors: narrow counters saturate at 15.
    pulse_start();
    for (int i = 0; i < 20; i++) push(mk(i == 19, '1));
    wait_done("sat");
    chk("sat_b_vcnt",  64'(b_vcnt),  64'd15);
    chk("sat_b_fcnt",  64'(b_fcnt),  64'd15);
    chk("sat_b_first", 64'(b_first), 64'd0);
    chk("sat_a_vcnt",  64'(a_vcnt),  64'd20);
    chk("sat_a_fcnt",  64'(a_fcnt),  64'd20);
    chk("sat_b_pass",  64'(b_pass),  64'h0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
